// File: rtl/multi_dataflow_mac_mdc_tcdm_package.sv
// Shared types and sizing helpers for the multi-bank TCDM responder.
package multi_dataflow_mac_mdc_tcdm_package;

  localparam int unsigned MP_DEF    = 4;
  localparam int unsigned NB_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 1024;
  localparam int unsigned WORD_OFF  = 2;

  // Index width that never collapses to zero, so single-entry selects stay legal
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BANK_IDX_W = idx_w(NB_DEF);
  localparam int unsigned ROW_IDX_W  = idx_w(DEPTH_DEF);

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_resp_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response channel between an accelerator master and a memory slave.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/multi_dataflow_mac_mdc_tcdm_rr_arb.sv
// Per-bank round-robin arbiter: one-hot grant, pointer advances past the winner.
module multi_dataflow_mac_mdc_tcdm_rr_arb
  import multi_dataflow_mac_mdc_tcdm_package::*;
#(
  parameter int unsigned MP = MP_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [MP-1:0] req_i,
  output logic [MP-1:0] gnt_o
);

  localparam int unsigned PTR_W = idx_w(MP);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;
  int unsigned      idx;

  always_comb begin
    gnt_o    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < MP; i++) begin
      idx = (32'(rr_ptr_q) + i) % MP;
      if (!found && req_i[idx[PTR_W-1:0]]) begin
        gnt_o[idx[PTR_W-1:0]] = 1'b1;
        rr_ptr_d              = PTR_W'((idx + 1) % MP);
        found                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/multi_dataflow_mac_mdc_tcdm_responder.sv
// Word-interleaved multi-bank TCDM scratchpad with per-bank round-robin arbitration.
// Optional random back-pressure per port when MAC_MDC_TCDM_STALL_EN is defined.
module multi_dataflow_mac_mdc_tcdm_responder
  import multi_dataflow_mac_mdc_tcdm_package::*;
#(
  parameter int unsigned MP    = MP_DEF,
  parameter int unsigned NB    = NB_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  hwpe_stream_intf_tcdm.slave tcdm [MP-1:0]
);

  localparam int unsigned BANK_W  = (NB == NB_DEF) ? BANK_IDX_W : idx_w(NB);
  localparam int unsigned ROW_W   = (DEPTH == DEPTH_DEF) ? ROW_IDX_W : idx_w(DEPTH);
  localparam int unsigned LOG2_NB = $clog2(NB);

  tcdm_req_t                req_s  [MP];
  logic [MP-1:0]            req_v;
  logic [BANK_W-1:0]        bank_s [MP];
  logic [ROW_W-1:0]         row_s  [MP];
  logic [MP-1:0]            stall_s;
  logic [MP-1:0]            gnt_s;
  logic [NB-1:0][MP-1:0]    bank_gnt;
  logic [NB-1:0][31:0]      rdata_s;
  tcdm_resp_t               resp_q [MP];
  tcdm_resp_t               resp_d [MP];

  for (genvar p = 0; p < MP; p++) begin : g_port
    assign req_v[p]  = tcdm[p].req;
    assign req_s[p]  = '{add: tcdm[p].add, wen: tcdm[p].wen, be: tcdm[p].be, data: tcdm[p].data};
    // Higher address bits are masked off, so out-of-range addresses wrap
    assign bank_s[p] = BANK_W'((req_s[p].add >> WORD_OFF) & 32'(NB - 1));
    assign row_s[p]  = ROW_W'((req_s[p].add >> (WORD_OFF + LOG2_NB)) & 32'(DEPTH - 1));
    assign tcdm[p].gnt     = gnt_s[p];
    assign tcdm[p].r_data  = resp_q[p].r_data;
    assign tcdm[p].r_valid = resp_q[p].r_valid;
  end

`ifdef MAC_MDC_TCDM_STALL_EN
  logic [MP-1:0][15:0] lfsr_q, lfsr_d;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      lfsr_d[p]  = {lfsr_q[p][14:0], lfsr_q[p][15] ^ lfsr_q[p][13] ^ lfsr_q[p][12] ^ lfsr_q[p][10]};
      stall_s[p] = lfsr_q[p][0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < MP; p++) lfsr_q[p] <= 16'hACE1 + 16'(p);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall_s = '0;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [MP-1:0]    breq;
    logic [31:0]      mem_q [DEPTH];
    logic             sel_vld;
    logic             sel_wen;
    logic [3:0]       sel_be;
    logic [31:0]      sel_data;
    logic [ROW_W-1:0] sel_row;

    always_comb begin
      breq = '0;
      for (int p = 0; p < MP; p++)
        breq[p] = req_v[p] && !stall_s[p] && (bank_s[p] == BANK_W'(b));
    end

    multi_dataflow_mac_mdc_tcdm_rr_arb #(.MP(MP)) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (breq),
      .gnt_o  (bank_gnt[b])
    );

    always_comb begin
      sel_vld  = 1'b0;
      sel_wen  = 1'b1;
      sel_be   = '0;
      sel_data = '0;
      sel_row  = '0;
      for (int p = 0; p < MP; p++) begin
        if (bank_gnt[b][p]) begin
          sel_vld  = rst_ni;
          sel_wen  = req_s[p].wen;
          sel_be   = req_s[p].be;
          sel_data = req_s[p].data;
          sel_row  = row_s[p];
        end
      end
    end

    // Storage is deliberately unreset
    always_ff @(posedge clk_i) begin
      if (sel_vld && !sel_wen) begin
        for (int i = 0; i < 4; i++)
          if (sel_be[i]) mem_q[sel_row][8*i +: 8] <= sel_data[8*i +: 8];
      end
    end

    assign rdata_s[b] = mem_q[sel_row];
  end

  always_comb begin
    gnt_s = '0;
    for (int b = 0; b < NB; b++) gnt_s = gnt_s | bank_gnt[b];
    if (!rst_ni) gnt_s = '0;
  end

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      resp_d[p]         = resp_q[p];
      resp_d[p].r_valid = gnt_s[p];
      if (gnt_s[p]) resp_d[p].r_data = req_s[p].wen ? rdata_s[bank_s[p]] : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < MP; p++) resp_q[p] <= '0;
    end else begin
      for (int p = 0; p < MP; p++) resp_q[p] <= resp_d[p];
    end
  end

endmodule
